// File: rtl/mem_access_controller.sv
// mem_access_controller
// MEM-stage load/store sequencer for a single-port req/ack data bus.
// Issues one bus transaction per aligned access, stalls the pipeline while it
// is outstanding, aligns/extends read data and reports misaligned accesses
// and bus timeouts as single-cycle pulses.

`ifndef LOAD_LB
`define LOAD_LB  3'b000
`define LOAD_LH  3'b001
`define LOAD_LW  3'b010
`define LOAD_LBU 3'b011
`define LOAD_LHU 3'b100
`define LOAD_DEF 3'b101
`endif

`ifndef STORE_SB
`define STORE_SB  2'b00
`define STORE_SH  2'b01
`define STORE_SW  2'b10
`define STORE_DEF 2'b11
`endif

module mem_access_controller #(
  // Cycles spent waiting for bus_ack before the access is aborted (>= 1).
  parameter int unsigned TIMEOUT_CYCLES = 255,
  // Timeout counter width; 2**CNT_W must exceed TIMEOUT_CYCLES.
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  // Decoded MEM-stage controls
  input  logic        mem_write,
  input  logic        wb_load,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  // Pipeline / writeback side
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_err,
  // Data bus master
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Last counter value that still waits; the next ack-less cycle aborts.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Access decode helpers
  // ---------------------------------------------------------------------------

  // Byte enables for a store of the given type at byte offset off.
  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] off);
    logic [3:0] be;
    case (st)
      `STORE_SB: be = 4'b0001 << off;
      `STORE_SH: be = off[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane it could occupy.
  function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] d);
    logic [31:0] w;
    case (st)
      `STORE_SB: w = {4{d[7:0]}};
      `STORE_SH: w = {2{d[15:0]}};
      default:   w = d;
    endcase
    return w;
  endfunction

  // Misalignment check; byte accesses are always aligned and LOAD_DEF is a word.
  function automatic logic check_misaligned(input logic       is_st,
                                            input logic [1:0] st,
                                            input logic [2:0] lt,
                                            input logic [1:0] off);
    logic half;
    logic byte_acc;
    if (is_st) begin
      half     = (st == `STORE_SH);
      byte_acc = (st == `STORE_SB);
    end else begin
      half     = (lt == `LOAD_LH) || (lt == `LOAD_LHU);
      byte_acc = (lt == `LOAD_LB) || (lt == `LOAD_LBU);
    end
    if (byte_acc) return 1'b0;
    if (half)     return off[0];
    return |off;
  endfunction

  // Lane select and sign/zero extension of a returned bus word.
  function automatic logic [31:0] extract_load(input logic [31:0] w,
                                               input logic [2:0]  lt,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (lt)
      `LOAD_LB:  r = {{24{b[7]}}, b};
      `LOAD_LH:  r = {{16{h[15]}}, h};
      `LOAD_LBU: r = {24'd0, b};
      `LOAD_LHU: r = {16'd0, h};
      default:   r = w;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e            state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              bus_req_q,    bus_req_d;
  logic              bus_we_q,     bus_we_d;
  logic [31:0]       bus_addr_q,   bus_addr_d;
  logic [31:0]       bus_wdata_q,  bus_wdata_d;
  logic [3:0]        bus_be_q,     bus_be_d;
  logic [2:0]        ld_type_q,    ld_type_d;
  logic [1:0]        ld_off_q,     ld_off_d;
  logic [31:0]       load_data_q,  load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              bus_err_q,    bus_err_d;

  logic is_store;
  logic access_valid;
  logic access_mis;
  logic stall_c;
  logic mis_c;

  assign is_store     = mem_write && (mem_store_type != `STORE_DEF);
  assign access_valid = wb_load || is_store;
  assign access_mis   = check_misaligned(is_store, mem_store_type, mem_load_type, addr[1:0]);

  // Next-state, bus register and combinational output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    ld_type_d    = ld_type_q;
    ld_off_d     = ld_off_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    stall_c      = 1'b0;
    mis_c        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access_valid) begin
          if (access_mis) begin
            mis_c = 1'b1;
          end else begin
            stall_c    = 1'b1;
            state_d    = S_REQ;
            cnt_d      = '0;
            bus_req_d  = 1'b1;
            bus_we_d   = is_store;
            bus_addr_d = {addr[31:2], 2'b00};
            ld_type_d  = mem_load_type;
            ld_off_d   = addr[1:0];
            if (is_store) begin
              bus_be_d    = store_be(mem_store_type, addr[1:0]);
              bus_wdata_d = store_wdata(mem_store_type, store_data);
            end else begin
              bus_be_d    = 4'b1111;
            end
          end
        end
      end

      S_REQ: begin
        stall_c = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = S_DONE;
          if (!bus_we_q) begin
            load_data_d  = extract_load(bus_rdata, ld_type_q, ld_off_q);
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d   = 1'b0;
          state_d     = S_DONE;
          bus_err_d   = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // One-cycle release: the pipeline advances, so the access inputs still
      // visible here belong to the finished instruction and are not re-issued.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, all cleared the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      ld_type_q    <= '0;
      ld_off_q     <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      ld_type_q    <= ld_type_d;
      ld_off_q     <= ld_off_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Combinational pulses are masked during reset so stall drops immediately.
  assign stall      = stall_c && !rst;
  assign misaligned = mis_c && !rst;

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller
// Scoreboarded bench: the driver pushes expected bus/writeback events computed
// by a byte-arithmetic reference model; a monitor pops and compares them.

`ifndef LOAD_LB
`define LOAD_LB  3'b000
`define LOAD_LH  3'b001
`define LOAD_LW  3'b010
`define LOAD_LBU 3'b011
`define LOAD_LHU 3'b100
`define LOAD_DEF 3'b101
`endif

`ifndef STORE_SB
`define STORE_SB  2'b00
`define STORE_SH  2'b01
`define STORE_SW  2'b10
`define STORE_DEF 2'b11
`endif

module tb_mem_access_controller;

  localparam int TO = 4;

  localparam logic [2:0] LT_LB  = `LOAD_LB;
  localparam logic [2:0] LT_LH  = `LOAD_LH;
  localparam logic [2:0] LT_LW  = `LOAD_LW;
  localparam logic [2:0] LT_LBU = `LOAD_LBU;
  localparam logic [2:0] LT_LHU = `LOAD_LHU;
  localparam logic [2:0] LT_DEF = `LOAD_DEF;
  localparam logic [1:0] ST_SB  = `STORE_SB;
  localparam logic [1:0] ST_SH  = `STORE_SH;
  localparam logic [1:0] ST_SW  = `STORE_SW;
  localparam logic [1:0] ST_DEF = `STORE_DEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write, wb_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_store_type;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, misaligned, bus_err;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  mem_access_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .mem_write(mem_write), .wb_load(wb_load),
    .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
    .addr(addr), .store_data(store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef enum logic [1:0] {EV_BUS, EV_LOAD, EV_ERR, EV_MIS} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
  } ev_t;

  ev_t         sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_load = '0;
  logic [3:0]  mon_be;
  logic [31:0] mon_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int ld_size(input logic [2:0] t);
    if (t == LT_LB || t == LT_LBU) return 1;
    if (t == LT_LH || t == LT_LHU) return 2;
    return 4;
  endfunction

  function automatic int st_size(input logic [1:0] t);
    if (t == ST_SB) return 1;
    if (t == ST_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] rd);
    int          sz;
    logic [31:0] mask, v;
    sz   = ld_size(t);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rd >> (8 * (a % 4))) & mask;
    if ((t == LT_LB || t == LT_LH) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] t, input logic [31:0] a);
    logic [3:0] be;
    int off, sz;
    off = int'(a % 4);
    sz  = st_size(t);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] t, input logic [31:0] d);
    logic [31:0] w;
    int sz;
    sz = st_size(t);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic ev_t mk_ev(input ev_kind_e k, input logic [31:0] a, input logic we,
                                input logic [3:0] be, input logic [31:0] wd, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.data = d;
    return e;
  endfunction

  // ---------------- monitor ----------------
  task automatic expect_event(input ev_kind_e kind);
    ev_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s with nothing expected", kind.name());
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind) begin
      n_fail++;
      $display("FAIL event_order: got %s, expected %s", kind.name(), e.kind.name());
      return;
    end
    case (kind)
      EV_BUS: begin
        check("bus_addr", bus_addr, e.addr);
        check("bus_we", 32'(bus_we), 32'(e.we));
        check("bus_be", 32'(bus_be), 32'(e.be));
        if (e.we) check("bus_wdata", bus_wdata, e.wdata);
      end
      EV_LOAD: check("load_data", load_data, e.data);
      EV_ERR:  check("err_load_data", load_data, 32'd0);
      default: check("mis_bus_req", 32'(bus_req), 32'd0);
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (bus_req && bus_ack) begin
          mon_be    = bus_be;
          mon_wdata = bus_wdata;
          expect_event(EV_BUS);
        end
        if (misaligned) expect_event(EV_MIS);
        if (load_valid) expect_event(EV_LOAD);
        if (bus_err)    expect_event(EV_ERR);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_idle();
    mem_write = 1'b0; wb_load = 1'b0;
    mem_load_type = LT_LW; mem_store_type = ST_DEF;
    addr = $urandom(); store_data = $urandom();
  endtask

  // Entered and left at 1 time unit after a rising edge.
  // k = wait cycles before ack; k >= TO means the slave never acks.
  task automatic do_access(input string tag, input bit st, input logic [2:0] lt,
                           input logic [1:0] stp, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input int k);
    bit valid, mis, to;
    int sz, nstall;
    logic [31:0] exp_ld;
    valid = st ? (stp != ST_DEF) : 1'b1;
    sz    = st ? st_size(stp) : ld_size(lt);
    mis   = valid && ((a % sz) != 0);
    to    = (k >= TO);
    mem_write = st; wb_load = !st; mem_load_type = lt; mem_store_type = stp;
    addr = a; store_data = sd; bus_ack = 1'b0;

    if (!valid || mis) begin
      if (mis) sb.push_back(mk_ev(EV_MIS, '0, 1'b0, '0, '0, '0));
      @(negedge clk);
      check({tag, "_nostall"}, 32'(stall), 32'd0);
      check({tag, "_mis_flag"}, 32'(misaligned), 32'(mis));
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check({tag, "_no_req"}, 32'(bus_req), 32'd0);
      @(posedge clk); #1;
      return;
    end

    if (!to)
      sb.push_back(mk_ev(EV_BUS, {a[31:2], 2'b00}, st, st ? model_be(stp, a) : 4'hF,
                         st ? model_wdata(stp, sd) : 32'd0, '0));
    if (!st) begin
      exp_ld = to ? 32'd0 : model_load(lt, a, rd);
      sb.push_back(mk_ev(to ? EV_ERR : EV_LOAD, '0, 1'b0, '0, '0, exp_ld));
      last_load = exp_ld;
    end else if (to) begin
      sb.push_back(mk_ev(EV_ERR, '0, 1'b0, '0, '0, '0));
      last_load = '0;
    end

    nstall = 0;
    @(negedge clk);
    if (stall) nstall++;
    for (int j = 0; j < TO; j++) begin
      @(posedge clk); #1;
      bus_ack   = (j == k);
      bus_rdata = (j == k) ? rd : $urandom();
      @(negedge clk);
      if (stall) nstall++;
      check({tag, "_req_held"}, 32'(bus_req), 32'd1);
      check({tag, "_addr_held"}, bus_addr, {a[31:2], 2'b00});
      if (j == k) break;
    end
    @(posedge clk); #1;
    bus_ack = 1'(($urandom() % 2));
    @(negedge clk);
    check({tag, "_done_stall"}, 32'(stall), 32'd0);
    check({tag, "_done_req"}, 32'(bus_req), 32'd0);
    check({tag, "_load_valid"}, 32'(load_valid), 32'(!st && !to));
    check({tag, "_bus_err"}, 32'(bus_err), 32'(to));
    check({tag, "_load_hold"}, load_data, last_load);
    check({tag, "_stall_cycles"}, 32'(nstall), to ? 32'(TO + 1) : 32'(k + 2));
    @(posedge clk); #1;
    bus_ack = 1'b0;
    drive_idle();
    @(negedge clk);
    check({tag, "_no_reissue"}, 32'(bus_req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [2:0] lts[6];
  logic [1:0] sts[3];

  initial begin
    lts = '{LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU, LT_DEF};
    sts = '{ST_SB, ST_SH, ST_SW};
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    drive_idle();
    repeat (2) @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_pulses", {29'd0, load_valid, bus_err, misaligned}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios
    do_access("lb", 1'b0, LT_LB, ST_DEF, 32'h0000_1003, '0, 32'h80FF_1234, 0);
    check("lb_value", load_data, 32'hFFFF_FF80);
    do_access("lhu", 1'b0, LT_LHU, ST_DEF, 32'h0000_2002, '0, 32'h9ABC_5678, 3);
    check("lhu_value", load_data, 32'h0000_9ABC);
    do_access("sb", 1'b1, LT_LW, ST_SB, 32'h0000_0010, 32'h0000_00A5, '0, 1);
    check("sb_be", 32'(mon_be), 32'h1);
    check("sb_wdata", mon_wdata, 32'hA5A5_A5A5);
    do_access("sh", 1'b1, LT_LW, ST_SH, 32'h0000_0012, 32'h1234_BEEF, '0, 0);
    check("sh_be", 32'(mon_be), 32'hC);
    do_access("sw_mis", 1'b1, LT_LW, ST_SW, 32'h0000_0006, 32'h1111_2222, '0, 0);
    do_access("lh_mis", 1'b0, LT_LH, ST_DEF, 32'h0000_0001, '0, '0, 0);
    do_access("ld_timeout", 1'b0, LT_LW, ST_DEF, 32'h0000_3000, '0, '0, TO);
    check("timeout_value", load_data, 32'd0);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      int sel, k, sz, gap;
      bit st;
      logic [2:0] lt;
      logic [1:0] stp;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      st  = (sel >= 5);
      lt  = lts[$urandom_range(0, 5)];
      stp = (sel == 9) ? ST_DEF : sts[$urandom_range(0, 2)];
      sz  = st ? st_size(stp) : ld_size(lt);
      a   = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 32'd1);
      k   = st ? $urandom_range(0, TO - 1) : $urandom_range(0, TO);
      do_access("rnd", st, lt, stp, a, $urandom(), $urandom(), k);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus_ack = 1'b1;
        @(negedge clk);
        check("idle_ack_ignored", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
      end
    end

    // Reset in the second REQ cycle of a load
    mem_write = 1'b0; wb_load = 1'b1; mem_load_type = LT_LW; addr = 32'h0000_0040;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_bus_req", 32'(bus_req), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_load_data", load_data, 32'd0);
    check("midrst_bus_addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b0;
    last_load = '0;
    @(negedge clk);
    check("post_rst_idle", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    do_access("sw_after_rst", 1'b1, LT_LW, ST_SW, 32'h0000_0020, 32'hCAFE_F00D, '0, 1);
    check("sw_after_rst_wdata", mon_wdata, 32'hCAFE_F00D);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
